// File: rtl/delay_line_ctrl.sv
// Write/read sequencer for the delay RAM: write pointer, delayed read address, priming after each delay load.
// Optional DLY_FILL_LEVEL_EN adds the fill_lvl output (priming progress / active delay).
module delay_line_ctrl #(
  parameter int A_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [A_WIDTH-1:0] delay,
  input  logic               delay_ld,
  output logic               wr_en,
  output logic [A_WIDTH-1:0] wr_addr,
  output logic               rd_en,
  output logic [A_WIDTH-1:0] rd_addr,
  output logic               dout_vld,
  output logic               priming
`ifdef DLY_FILL_LEVEL_EN
  ,
  output logic [A_WIDTH-1:0] fill_lvl
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [A_WIDTH-1:0] wptr_q, wptr_d;
  logic [A_WIDTH-1:0] delay_q, delay_d;
  logic [A_WIDTH-1:0] prime_cnt_q, prime_cnt_d;
  logic               vld_p1;

  // A zero delay would read and write the same address in one cycle.
  function automatic logic [A_WIDTH-1:0] clamp_delay(input logic [A_WIDTH-1:0] d);
    return (d == '0) ? A_WIDTH'(1) : d;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wptr_q      <= '0;
      delay_q     <= A_WIDTH'(1);
      prime_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      delay_q     <= delay_d;
      prime_cnt_q <= prime_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    delay_d     = delay_q;
    prime_cnt_d = prime_cnt_q;
    wr_en       = en && (state_q != IDLE);
    rd_en       = en && (state_q == RUN) && !delay_ld;

    if (wr_en) wptr_d = wptr_q + A_WIDTH'(1);

    // A load restarts priming from any state; the load-cycle write is not counted.
    if (delay_ld) begin
      delay_d     = clamp_delay(delay);
      prime_cnt_d = '0;
      state_d     = PRIME;
    end else begin
      unique case (state_q)
        IDLE: ;
        PRIME: begin
          if (en) begin
            if (prime_cnt_q == delay_q - A_WIDTH'(1)) state_d = RUN;
            else                                      prime_cnt_d = prime_cnt_q + A_WIDTH'(1);
          end
        end
        RUN: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // p1: RAM read data is registered, so valid follows rd_en by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= rd_en;
  end

  assign wr_addr  = wptr_q;
  assign rd_addr  = wptr_q - delay_q;
  assign dout_vld = vld_p1;
  assign priming  = (state_q == PRIME);

`ifdef DLY_FILL_LEVEL_EN
  always_comb begin
    fill_lvl = '0;
    if (state_q == PRIME)    fill_lvl = prime_cnt_q;
    else if (state_q == RUN) fill_lvl = delay_q;
  end
`endif

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Testbench for delay_line_ctrl: vector table, directed corner sequences, randomized run vs. reference model.
module tb_delay_line_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] delay = '0;
  logic       delay_ld = 1'b0;
  logic       wr_en, rd_en, dout_vld, priming;
  logic [7:0] wr_addr, rd_addr;
`ifdef DLY_FILL_LEVEL_EN
  logic [7:0] fill_lvl;
`endif

  always #5 clk = ~clk;

  delay_line_ctrl #(.A_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .en(en), .delay(delay), .delay_ld(delay_ld),
    .wr_en(wr_en), .wr_addr(wr_addr), .rd_en(rd_en), .rd_addr(rd_addr),
    .dout_vld(dout_vld), .priming(priming)
`ifdef DLY_FILL_LEVEL_EN
    , .fill_lvl(fill_lvl)
`endif
  );

  // Simple registered-read RAM driven by the DUT addresses.
  logic [15:0] wdata = '0;
  logic [15:0] ram [0:255];
  logic [15:0] rdata = '0;
  always @(posedge clk) begin
    if (wr_en) ram[wr_addr] <= wdata;
    if (rd_en) rdata <= ram[rd_addr];
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts writes since the last load, not FSM states.
  bit          m_loaded;
  int          m_wptr, m_dq, m_cnt, m_nw;
  bit          m_dv;
  logic [15:0] hist [0:255];
  logic [15:0] m_exp_data;

  task automatic model_reset();
    m_loaded = 0; m_wptr = 0; m_dq = 1; m_cnt = 0; m_dv = 0;
  endtask

  function automatic bit e_wr();
    return en && m_loaded;
  endfunction
  function automatic bit e_rd();
    return en && m_loaded && (m_cnt >= m_dq) && !delay_ld;
  endfunction

  task automatic check_model();
    chk("wr_en", wr_en, e_wr());
    chk("rd_en", rd_en, e_rd());
    chk("wr_addr", wr_addr, m_wptr);
    chk("rd_addr", rd_addr, (m_wptr - m_dq + 256) % 256);
    chk("priming", priming, m_loaded && (m_cnt < m_dq));
    chk("dout_vld", dout_vld, m_dv);
    if (m_dv) chk("dout_data", rdata, m_exp_data);
`ifdef DLY_FILL_LEVEL_EN
    chk("fill_lvl", fill_lvl, !m_loaded ? 0 : (m_cnt < m_dq ? m_cnt : m_dq));
`endif
  endtask

  task automatic drive(input bit e, input bit l, input int d);
    @(negedge clk);
    en = e; delay_ld = l; delay = 8'(d); wdata = 16'($urandom);
    #4;
  endtask

  task automatic advance();
    bit w, r;
    w = e_wr(); r = e_rd();
    if (r) m_exp_data = hist[(m_nw - m_dq) % 256];
    if (w) begin hist[m_nw % 256] = wdata; m_nw++; end
    @(posedge clk);
    m_dv = r;
    if (w) m_wptr = (m_wptr + 1) % 256;
    if (delay_ld) begin
      m_loaded = 1; m_dq = (delay == 0) ? 1 : int'(delay); m_cnt = 0;
    end else if (w && m_cnt < m_dq) m_cnt++;
  endtask

  task automatic step(input bit e, input bit l, input int d);
    drive(e, l, d);
    check_model();
    advance();
  endtask

  typedef struct {
    bit en; bit ld; int dly;
    bit wr; bit rd; int wa; int ra; bit pr; bit dv;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(bit e, bit l, int d, bit w, bit r, int wa, int ra, bit p, bit v);
    vec_t t;
    t.en = e; t.ld = l; t.dly = d; t.wr = w; t.rd = r; t.wa = wa; t.ra = ra; t.pr = p; t.dv = v;
    tbl.push_back(t);
  endfunction

  initial begin
    int nreads;
    bit seen_vld, wrap_seen;
    m_nw = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    drive(0, 0, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_rd_addr", rd_addr, 255);
    chk("rst_priming", priming, 0);
    chk("rst_dout_vld", dout_vld, 0);
    advance();

    // en ignored in IDLE, load delay 4, prime, run; then load delay 0
    for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 0, 0, 255, 0, 0);
    add(0, 1, 4, 0, 0, 0, 255, 0, 0);
    add(1, 0, 0, 1, 0, 0, 252, 1, 0);
    add(1, 0, 0, 1, 0, 1, 253, 1, 0);
    add(1, 0, 0, 1, 0, 2, 254, 1, 0);
    add(1, 0, 0, 1, 0, 3, 255, 1, 0);
    add(1, 0, 0, 1, 1, 4, 0, 0, 0);
    add(1, 0, 0, 1, 1, 5, 1, 0, 1);
    add(0, 1, 0, 0, 0, 6, 2, 0, 1);
    add(1, 0, 0, 1, 0, 6, 5, 1, 0);
    add(1, 0, 0, 1, 1, 7, 6, 0, 0);
    add(1, 0, 0, 1, 1, 8, 7, 0, 1);
    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].ld, tbl[i].dly);
      chk($sformatf("tbl%0d_wr_en", i), wr_en, tbl[i].wr);
      chk($sformatf("tbl%0d_rd_en", i), rd_en, tbl[i].rd);
      chk($sformatf("tbl%0d_wr_addr", i), wr_addr, tbl[i].wa);
      chk($sformatf("tbl%0d_rd_addr", i), rd_addr, tbl[i].ra);
      chk($sformatf("tbl%0d_priming", i), priming, tbl[i].pr);
      chk($sformatf("tbl%0d_dout_vld", i), dout_vld, tbl[i].dv);
      check_model();
      advance();
    end

    // Reload delay together with en while running
    step(0, 1, 4);
    repeat (7) step(1, 0, 0);
    drive(1, 1, 2);
    chk("ld_en_wr_en", wr_en, 1);
    chk("ld_en_rd_en", rd_en, 0);
    check_model(); advance();
    drive(1, 0, 0);
    chk("reprime1_priming", priming, 1);
    chk("reprime1_rd_en", rd_en, 0);
    check_model(); advance();
    drive(1, 0, 0);
    chk("reprime2_priming", priming, 1);
    check_model(); advance();
    drive(1, 0, 0);
    chk("resume_rd_en", rd_en, 1);
    chk("resume_rd_addr", rd_addr, int'(wr_addr - 8'd2));
    check_model(); advance();
    step(1, 0, 0);

    // Asynchronous reset mid-stream
    drive(1, 0, 0);
    chk("pre_rst_dout_vld", dout_vld, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_dout_vld", dout_vld, 0);
    chk("async_rst_wr_addr", wr_addr, 0);
    chk("async_rst_priming", priming, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, 0);
    chk("post_rst_wr_en", wr_en, 0);
    chk("post_rst_wr_addr", wr_addr, 0);
    check_model(); advance();

    // Pointer wrap with delay 3
    step(0, 1, 3);
    seen_vld = 0; wrap_seen = 0;
    for (int i = 0; i < 300; i++) begin
      drive(1, 0, 0);
      if (seen_vld) chk("vld_gap", dout_vld, 1);
      if (dout_vld) seen_vld = 1;
      if (i > 200 && wr_addr == 8'd1) begin
        wrap_seen = 1;
        chk("wrap_rd_addr", rd_addr, 254);
      end
      check_model(); advance();
    end
    chk("wrap_seen", wrap_seen, 1);

    // Maximum delay 255
    step(0, 1, 255);
    nreads = 0;
    for (int i = 0; i < 260; i++) begin
      drive(1, 0, 0);
      if (rd_en) nreads++;
      check_model(); advance();
    end
    chk("dly255_reads", nreads, 5);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int r, d;
      r = int'($urandom_range(0, 9));
      d = (r == 0) ? 0 : (r == 1) ? 255 : int'($urandom_range(1, 20));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
